// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared types and 50 MHz default timing constants for button_event
package button_event_pkg;

  // Gesture classifier states
  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG
  } state_t;

  localparam int CNT_W_DEF        = 26;
  localparam int LONG_TICKS_DEF   = 25_000_000;  // 500 ms hold
  localparam int GAP_TICKS_DEF    = 12_500_000;  // 250 ms release-to-press window
  localparam int REPEAT_TICKS_DEF = 5_000_000;   // 100 ms auto-repeat period

endpackage

// File: rtl/button_event_timer.sv
// rtl/button_event_timer.sv - saturating up-counter shared by all button_event timeouts
module event_timer
  import button_event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; hold at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - short/long/double-click classifier; auto-repeat under BUTTON_EVENT_REPEAT_EN
module button_event
  import button_event_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int GAP_TICKS    = GAP_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk50m,
  input  logic rst,
  input  logic sw_hi,
  input  logic sw_lo,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_evt,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer;
  logic             timer_clr;
  logic             hi, lo;
  logic             long_hit, gap_hit;
  logic             short_d, long_d, double_d, repeat_d, busy_d;
  logic             short_q, long_q, double_q, busy_q;

  // A simultaneous press and release is contradictory, so neither is acted on
  assign hi       = sw_hi & ~sw_lo;
  assign lo       = sw_lo & ~sw_hi;
  assign long_hit = (timer == LONG_LAST);
  assign gap_hit  = (timer == GAP_LAST);

  // State register
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: button edges take priority over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hi) state_d = PRESS1;
      PRESS1:  if (lo) state_d = GAP;    else if (long_hit) state_d = LONG;
      GAP:     if (hi) state_d = PRESS2; else if (gap_hit)  state_d = IDLE;
      PRESS2:  if (lo) state_d = IDLE;   else if (long_hit) state_d = LONG;
      LONG:    if (lo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Event decisions for the current cycle, registered below
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      PRESS1: long_d = !lo && long_hit;
      GAP:    short_d = !hi && gap_hit;
      PRESS2: begin
        double_d = lo;
        // Holding the second press long: the first click still counts as a short press
        short_d  = !lo && long_hit;
        long_d   = !lo && long_hit;
      end
`ifdef BUTTON_EVENT_REPEAT_EN
      LONG:   repeat_d = !lo && (timer == CNT_W'(REPEAT_TICKS - 1));
`endif
      default: ;
    endcase
    // Busy stays up through the cycle that carries the closing event pulse
    busy_d = (state_d != IDLE) | short_d | long_d | double_d;
  end

  // Timer restarts on every state entry and on each auto-repeat reload
  assign timer_clr = (state_d != state_q) | repeat_d;

  event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk (clk50m),
    .rst (rst),
    .clr (timer_clr),
    .en  (1'b1),
    .cnt (timer)
  );

  // Output pulse registers
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = double_q;
  assign busy         = busy_q;

`ifdef BUTTON_EVENT_REPEAT_EN
  logic repeat_q;

  // Auto-repeat pulse register
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_evt = repeat_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = repeat_d | (REPEAT_TICKS == 0);
  assign repeat_evt        = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - self-checking bench for button_event against a deadline-based gesture model
module tb_button_event;

  localparam int LT = 8;
  localparam int GT = 4;
  localparam int RT = 3;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk50m = 1'b0;
  logic rst = 1'b1;
  logic sw_hi = 1'b0;
  logic sw_lo = 1'b0;
  logic short_press, long_press, double_click, repeat_evt, busy;

  button_event #(
    .CNT_W        (8),
    .LONG_TICKS   (LT),
    .GAP_TICKS    (GT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk50m       (clk50m),
    .rst          (rst),
    .sw_hi        (sw_hi),
    .sw_lo        (sw_lo),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .repeat_evt   (repeat_evt),
    .busy         (busy)
  );

  always #10 clk50m = ~clk50m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Gesture model: phase plus the absolute cycle at which the pending timeout pulse would appear
  localparam int P_IDLE = 0, P_HELD1 = 1, P_WAIT = 2, P_HELD2 = 3, P_HOLD = 4;
  int phase;
  int deadline;
  int cyc;
  int exp_vec;

  task automatic model(input logic h, input logic l);
    bit press, release_, due;
    bit e_s, e_l, e_d, e_r;
    press    = h && !l;
    release_ = l && !h;
    due      = (cyc + 1 == deadline);
    {e_s, e_l, e_d, e_r} = 4'b0;
    case (phase)
      P_IDLE:  if (press) begin phase = P_HELD1; deadline = cyc + 1 + LT; end
      P_HELD1: if (release_) begin phase = P_WAIT; deadline = cyc + 1 + GT; end
               else if (due) begin phase = P_HOLD; e_l = 1; deadline = cyc + 1 + RT; end
      P_WAIT:  if (press) begin phase = P_HELD2; deadline = cyc + 1 + LT; end
               else if (due) begin phase = P_IDLE; e_s = 1; end
      P_HELD2: if (release_) begin phase = P_IDLE; e_d = 1; end
               else if (due) begin phase = P_HOLD; e_s = 1; e_l = 1; deadline = cyc + 1 + RT; end
      P_HOLD:  if (release_) phase = P_IDLE;
               else if (REP_EN && due) begin e_r = 1; deadline = cyc + 1 + RT; end
      default: phase = P_IDLE;
    endcase
    exp_vec = {27'd0, (phase != P_IDLE) || e_s || e_l || e_d, e_r, e_d, e_l, e_s};
  endtask

  int n_short, n_long, n_dbl, n_rep, n_busy;
  int first_short, first_long, first_dbl, first_rep, last_rep, busy_fall;
  bit prev_busy;

  function automatic int obs_vec();
    return {27'd0, busy, repeat_evt, double_click, long_press, short_press};
  endfunction

  task automatic clr_stats();
    {n_short, n_long, n_dbl, n_rep, n_busy} = '0;
    {first_short, first_long, first_dbl, first_rep, last_rep, busy_fall} = {6{-1}};
    prev_busy = 1'b0;
  endtask

  // Drive one cycle's inputs (called at a negedge), check outputs after the next posedge
  task automatic step(input logic h, input logic l);
    int t;
    sw_hi = h;
    sw_lo = l;
    model(h, l);
    @(negedge clk50m);
    t = cyc + 1;
    check("cycle_outputs", obs_vec(), exp_vec);
    if (short_press) begin n_short++; if (first_short < 0) first_short = t; end
    if (long_press) begin n_long++; if (first_long < 0) first_long = t; end
    if (double_click) begin n_dbl++; if (first_dbl < 0) first_dbl = t; end
    if (repeat_evt) begin n_rep++; if (first_rep < 0) first_rep = t; last_rep = t; end
    if (busy) n_busy++;
    if (prev_busy && !busy && busy_fall < 0) busy_fall = t;
    prev_busy = busy;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw_hi = 1'b0;
    sw_lo = 1'b0;
    @(negedge clk50m);
    @(negedge clk50m);
    check("reset_outputs", obs_vec(), 0);
    rst = 1'b0;
    phase = P_IDLE;
    deadline = -1;
    cyc = 0;
    clr_stats();
  endtask

  task automatic run_scn(input int len, input int ha, input int hb, input int la, input int lb);
    for (int c = 0; c < len; c++) step(c == ha || c == hb, c == la || c == lb);
  endtask

  initial begin
    // 1: single short click
    do_reset();
    run_scn(12, 0, -1, 3, -1);
    check("s1_short_at", first_short, 8);
    check("s1_short_n", n_short, 1);
    check("s1_long_n", n_long, 0);
    check("s1_dbl_n", n_dbl, 0);
    check("s1_busy_cycles", n_busy, 8);
    check("s1_busy_fall", busy_fall, 9);

    // 2: long press then release
    do_reset();
    run_scn(25, 0, -1, 20, -1);
    check("s2_long_at", first_long, 9);
    check("s2_long_n", n_long, 1);
    check("s2_short_n", n_short, 0);
    check("s2_busy_fall", busy_fall, 21);

    // 3: double click
    do_reset();
    run_scn(12, 0, 4, 2, 6);
    check("s3_dbl_at", first_dbl, 7);
    check("s3_dbl_n", n_dbl, 1);
    check("s3_short_n", n_short, 0);

    // 4: auto-repeat while held
    do_reset();
    run_scn(22, 0, -1, 16, -1);
    check("s4_long_at", first_long, 9);
    if (REP_EN) begin
      check("s4_rep_first", first_rep, 12);
      check("s4_rep_last", last_rep, 15);
      check("s4_rep_n", n_rep, 2);
    end else begin
      check("s4_rep_n", n_rep, 0);
    end

    // 5: reset mid-gesture aborts it
    do_reset();
    run_scn(4, 0, -1, -1, -1);
    rst = 1'b1;
    #2;
    check("s5_async_clear", obs_vec(), 0);
    @(negedge clk50m);
    rst = 1'b0;
    phase = P_IDLE;
    deadline = -1;
    cyc = 5;
    clr_stats();
    for (int c = 5; c < 16; c++) step(1'b0, c == 6);
    check("s5_pulses", n_short + n_long + n_dbl + n_rep, 0);
    check("s5_busy_cycles", n_busy, 0);

    // 6: lone release and simultaneous press/release in IDLE
    do_reset();
    run_scn(12, 5, -1, 0, 5);
    check("s6_busy_cycles", n_busy, 0);
    check("s6_pulses", n_short + n_long + n_dbl + n_rep, 0);

    // Randomised pulse streams checked cycle by cycle against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 12)      step(1'b1, 1'b0);
      else if (r < 24) step(1'b0, 1'b1);
      else if (r < 27) step(1'b1, 1'b1);
      else             step(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Press classifier placed directly downstream of the switch debouncer.
- Consumes the debouncer's single-cycle rising and falling edge pulses (sw_hi, sw_lo).
- Classifies each gesture as a short press, long press or double click, and emits one-cycle event pulses to the application logic (menu/mode FSMs).
- Optional auto-repeat while a long press is held.

Parameters:
- CNT_W, 26, width of the shared event timer in bits.
- LONG_TICKS, 25_000_000, hold time (in clk50m cycles) that qualifies a long press (500 ms at 50 MHz).
- GAP_TICKS, 12_500_000, maximum release-to-press gap that qualifies a double click (250 ms).
- REPEAT_TICKS, 5_000_000, auto-repeat period (100 ms); used only with BUTTON_EVENT_REPEAT_EN.

Ports:
- clk50m  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- sw_hi  input  1  one-cycle pulse, debounced press detected.
- sw_lo  input  1  one-cycle pulse, debounced release detected.
- short_press  output  1  one-cycle pulse, single short click recognised.
- long_press  output  1  one-cycle pulse, hold reached LONG_TICKS.
- double_click  output  1  one-cycle pulse, second click completed within the gap.
- repeat_evt  output  1  one-cycle auto-repeat pulse; constant 0 when the feature is compiled out.
- busy  output  1  high while a gesture is in progress (state != IDLE), registered.

Behaviour:
- Reset (async, active-high): state = IDLE, timer = 0, all outputs 0. Reset mid-gesture aborts the gesture with no pulse emitted.
- Event-pulse outputs are registered. The deciding condition is sampled in cycle N; the pulse is high in cycle N+1 for exactly one cycle.
- Same-cycle sw_hi and sw_lo: both are ignored, no state change, timer keeps counting.
- Timer: cleared to 0 on every state entry and incremented every cycle otherwise. It saturates at all-ones and never wraps. Required: LONG_TICKS and GAP_TICKS < 2**CNT_W.
- States and transitions:
  - IDLE: sw_hi -> PRESS1. sw_lo is ignored.
  - PRESS1:
    - sw_lo -> GAP.
    - timer == LONG_TICKS-1 -> LONG, and long_press fires.
    - sw_lo in the terminal cycle takes priority (-> GAP, no long_press).
  - GAP:
    - sw_hi -> PRESS2.
    - timer == GAP_TICKS-1 -> IDLE, and short_press fires.
    - sw_hi in the terminal cycle takes priority (-> PRESS2).
  - PRESS2:
    - sw_lo -> IDLE, and double_click fires (no short_press).
    - timer == LONG_TICKS-1 -> LONG; short_press (for the first click) and long_press fire in the same cycle.
  - LONG: sw_lo -> IDLE with no pulse. sw_hi is ignored.
- A stray sw_hi in PRESS1 or PRESS2 is ignored. A stray sw_lo in GAP is ignored.
- Latency:
  - short_press: GAP_TICKS+1 cycles after the sw_lo pulse.
  - long_press: LONG_TICKS+1 cycles after the sw_hi pulse.
  - double_click: 1 cycle after the second sw_lo.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined:
  - In LONG, the timer restarts on entry. Each time it reaches REPEAT_TICKS-1, repeat_evt pulses and the timer reloads to 0.
  - First repeat_evt arrives REPEAT_TICKS cycles after long_press; repetition stops on sw_lo.
  - sw_lo in a terminal cycle suppresses that repeat.
- Undefined: repeat_evt is tied to 0, the REPEAT_TICKS logic is absent, and LONG waits only for sw_lo.

Decomposition:
- Package button_event_pkg holds:
  - typedef enum state_t {IDLE, PRESS1, GAP, PRESS2, LONG};
  - default tick constants for 50 MHz;
  - constant CNT_W_DEF = 26.
- Sub-module event_timer (CNT_W wide):
  - inputs clr, en; output cnt (saturating up-counter);
  - comparator logic stays in button_event.
- FSM and output registers live in button_event.

Test Plan:
All scenarios use LONG_TICKS=8, GAP_TICKS=4, REPEAT_TICKS=3, with sw_hi/sw_lo pulses at cycle numbers relative to reset release.
1. sw_hi@0, sw_lo@3 -> short_press only @8; busy high cycles 1-8, low @9; long_press and double_click stay 0.
2. sw_hi@0, held -> long_press @9; sw_lo@20 -> busy low @21; no short_press.
3. sw_hi@0, sw_lo@2, sw_hi@4, sw_lo@6 -> double_click @7 only; short_press stays 0.
4. With BUTTON_EVENT_REPEAT_EN: sw_hi@0, sw_lo@16 -> long_press @9, repeat_evt @12 and @15, none after. Without the macro: repeat_evt stays 0.
5. sw_hi@0, rst pulsed @4, sw_lo@6 -> all outputs 0 from @4 onward, busy 0, no event pulse ever.
6. sw_lo@0 alone in IDLE, then sw_hi&sw_lo both @5 -> no state change, busy stays 0, no pulses.
